// File: rtl/vector_writeback_arbiter.sv
// rtl/vector_writeback_arbiter.sv - vector register file write-port arbiter (execute priority, buffered load returns)
// Define VREG_CLEAR_EN to zero all 32 vector registers after reset.
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif

module vector_writeback_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_ex_enable,
    input  logic [`REG_IDX_WIDTH-1:0] i_ex_reg,
    input  logic [511:0]              i_ex_value,
    input  logic [15:0]               i_ex_mask,
    input  logic                      i_mem_valid,
    output logic                      o_mem_ready,
    input  logic [`REG_IDX_WIDTH-1:0] i_mem_reg,
    input  logic [511:0]              i_mem_value,
    input  logic [15:0]               i_mem_mask,
    output logic                      o_wb_enable_vector_writeback,
    output logic [`REG_IDX_WIDTH-1:0] o_wb_writeback_reg,
    output logic [511:0]              o_wb_writeback_value,
    output logic [15:0]               o_wb_writeback_mask,
    output logic                      o_wb_stall_request,
    output logic                      o_clear_busy
);
    localparam int RW = `REG_IDX_WIDTH;
    localparam int EW = RW + 512 + 16;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [EW-1:0]  r_mem [FIFO_DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [SW-1:0]  r_starve;
    logic           r_wb_enable;
    logic [RW-1:0]  r_wb_reg;
    logic [511:0]   r_wb_value;
    logic [15:0]    r_wb_mask;
    logic           r_stall;
    logic           w_clear_busy;
    logic           w_ex;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic [EW-1:0]  w_head;

`ifdef VREG_CLEAR_EN
    logic           r_clear_busy;
    logic [4:0]     r_clear_idx;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clear_busy <= 1'b1;
            r_clear_idx  <= '0;
        end else if (r_clear_busy) begin
            r_clear_idx <= r_clear_idx + 5'd1;
            if (r_clear_idx == 5'd31)
                r_clear_busy <= 1'b0;
        end
    end

    assign w_clear_busy = r_clear_busy;
    assign o_clear_busy = r_clear_busy | i_reset;

    a_no_ex_during_clear: assert property (@(posedge i_clk) disable iff (i_reset)
        !(i_ex_enable && r_clear_busy));
`else
    assign w_clear_busy = 1'b0;
    assign o_clear_busy = 1'b0;
`endif

    // Execute results cannot stall, so they always win; the ready check ignores a same-cycle pop.
    assign w_ex        = i_ex_enable && !w_clear_busy;
    assign w_empty     = (r_count == '0);
    assign o_mem_ready = (r_count < DEPTH_C) && !w_clear_busy && !i_reset;
    assign w_push      = i_mem_valid && o_mem_ready;
    assign w_pop       = !w_ex && !w_empty && !w_clear_busy;
    assign w_head      = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {i_mem_reg, i_mem_value, i_mem_mask};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wb_enable <= 1'b0;
            r_wb_reg    <= '0;
            r_wb_value  <= '0;
            r_wb_mask   <= '0;
            r_stall     <= 1'b0;
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_starve    <= '0;
        end else begin
            r_wb_enable <= 1'b0;
            if (w_ex) begin
                r_wb_enable <= 1'b1;
                r_wb_reg    <= i_ex_reg;
                r_wb_value  <= i_ex_value;
                r_wb_mask   <= i_ex_mask;
            end else if (w_pop) begin
                r_wb_enable <= 1'b1;
                {r_wb_reg, r_wb_value, r_wb_mask} <= w_head;
            end
`ifdef VREG_CLEAR_EN
            if (r_clear_busy) begin
                r_wb_enable <= 1'b1;
                r_wb_reg    <= RW'(r_clear_idx);
                r_wb_value  <= '0;
                r_wb_mask   <= '1;
            end
`endif
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            // Counts consecutive cycles the FIFO head is blocked by execute traffic.
            if (w_pop || w_empty || w_clear_busy)
                r_starve <= '0;
            else if (w_ex && (r_starve != LIMIT_C))
                r_starve <= r_starve + SW'(1);
            r_stall <= (r_starve == LIMIT_C) && !w_pop;
        end
    end

    assign o_wb_enable_vector_writeback = r_wb_enable;
    assign o_wb_writeback_reg           = r_wb_reg;
    assign o_wb_writeback_value         = r_wb_value;
    assign o_wb_writeback_mask          = r_wb_mask;
    assign o_wb_stall_request           = r_stall;
endmodule

// File: tb/tb_vector_writeback_arbiter.sv
// tb/tb_vector_writeback_arbiter.sv - self-checking bench for vector_writeback_arbiter
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif

module tb_vector_writeback_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
`ifdef VREG_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_ex_enable = 1'b0;
    logic [4:0]   i_ex_reg = '0;
    logic [511:0] i_ex_value = '0;
    logic [15:0]  i_ex_mask = '0;
    logic         i_mem_valid = 1'b0;
    logic         o_mem_ready;
    logic [4:0]   i_mem_reg = '0;
    logic [511:0] i_mem_value = '0;
    logic [15:0]  i_mem_mask = '0;
    logic         o_wb_enable_vector_writeback;
    logic [4:0]   o_wb_writeback_reg;
    logic [511:0] o_wb_writeback_value;
    logic [15:0]  o_wb_writeback_mask;
    logic         o_wb_stall_request;
    logic         o_clear_busy;

    int checks = 0;
    int errors = 0;

    vector_writeback_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_ex_enable(i_ex_enable), .i_ex_reg(i_ex_reg), .i_ex_value(i_ex_value), .i_ex_mask(i_ex_mask),
        .i_mem_valid(i_mem_valid), .o_mem_ready(o_mem_ready), .i_mem_reg(i_mem_reg),
        .i_mem_value(i_mem_value), .i_mem_mask(i_mem_mask),
        .o_wb_enable_vector_writeback(o_wb_enable_vector_writeback),
        .o_wb_writeback_reg(o_wb_writeback_reg), .o_wb_writeback_value(o_wb_writeback_value),
        .o_wb_writeback_mask(o_wb_writeback_mask), .o_wb_stall_request(o_wb_stall_request),
        .o_clear_busy(o_clear_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]   r;
        logic [511:0] d;
        logic [15:0]  m;
    } ent_t;

    typedef struct {
        bit           v;
        logic [4:0]   r;
        logic [511:0] d;
        logic [15:0]  m;
        bit           s;
    } exp_t;

    ent_t   memq[$];
    exp_t   wbq[$];
    bit     m_live = 1'b0;
    int     m_cnt = 0;
    bit     m_stall = 1'b0;
    logic [4:0]   m_reg = '0;
    logic [511:0] m_val = '0;
    logic [15:0]  m_mask = '0;
    bit     clr_busy = 1'b0;
    int     clr_idx = 0;

    // Reference model: decides each cycle's writeback and pushes the expectation.
    always @(posedge clk) begin
        exp_t e;
        ent_t it;
        bit   rdy;
        bit   pop;
        bit   nstall;
        int   sz0;
        e.v = 1'b0;
        if (i_reset) begin
            memq.delete();
            m_live = 1'b1; m_cnt = 0; m_stall = 1'b0;
            m_reg = '0; m_val = '0; m_mask = '0;
            clr_busy = CLR; clr_idx = 0;
        end else if (m_live) begin
            if (clr_busy) begin
                e.v = 1'b1; m_reg = 5'(clr_idx); m_val = '0; m_mask = 16'hFFFF;
                if (clr_idx == 31) clr_busy = 1'b0;
                clr_idx++;
                m_cnt = 0; m_stall = 1'b0;
            end else begin
                sz0    = memq.size();
                rdy    = sz0 < DEPTH;
                pop    = !i_ex_enable && sz0 > 0;
                nstall = (m_cnt == LIMIT) && !pop;
                if (i_ex_enable) begin
                    e.v = 1'b1; m_reg = i_ex_reg; m_val = i_ex_value; m_mask = i_ex_mask;
                end else if (pop) begin
                    it = memq.pop_front();
                    e.v = 1'b1; m_reg = it.r; m_val = it.d; m_mask = it.m;
                end
                if (pop || sz0 == 0) m_cnt = 0;
                else if (i_ex_enable && m_cnt < LIMIT) m_cnt++;
                if (i_mem_valid && rdy) begin
                    it.r = i_mem_reg; it.d = i_mem_value; it.m = i_mem_mask;
                    memq.push_back(it);
                end
                m_stall = nstall;
            end
        end
        if (m_live) begin
            e.r = m_reg; e.d = m_val; e.m = m_mask; e.s = m_stall;
            wbq.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        bit   exp_rdy;
        bit   exp_clr;
        if (m_live && wbq.size() > 0) begin
            e = wbq.pop_front();
            checks++;
            if (o_wb_enable_vector_writeback !== e.v) begin
                errors++;
                $display("FAIL sb_wb_enable: got %b want %b at %0t", o_wb_enable_vector_writeback, e.v, $time);
            end
            checks++;
            if (o_wb_writeback_reg !== e.r || o_wb_writeback_mask !== e.m || o_wb_writeback_value !== e.d) begin
                errors++;
                $display("FAIL sb_wb_data: got reg=%0d mask=%h value=%h want reg=%0d mask=%h value=%h",
                         o_wb_writeback_reg, o_wb_writeback_mask, o_wb_writeback_value, e.r, e.m, e.d);
            end
            checks++;
            if (o_wb_stall_request !== e.s) begin
                errors++;
                $display("FAIL sb_stall: got %b want %b at %0t", o_wb_stall_request, e.s, $time);
            end
            exp_rdy = !i_reset && !clr_busy && (memq.size() < DEPTH);
            checks++;
            if (o_mem_ready !== exp_rdy) begin
                errors++;
                $display("FAIL sb_mem_ready: got %b want %b at %0t", o_mem_ready, exp_rdy, $time);
            end
            exp_clr = CLR && (i_reset || clr_busy);
            checks++;
            if (o_clear_busy !== exp_clr) begin
                errors++;
                $display("FAIL sb_clear_busy: got %b want %b at %0t", o_clear_busy, exp_clr, $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_ex_enable = 1'b0;
        i_mem_valid = 1'b0;
    endtask

    task automatic push_mem(input logic [4:0] r);
        bit rdy;
        bit done = 1'b0;
        i_mem_valid = 1'b1; i_mem_reg = r;
        i_mem_value = {16{$urandom}}; i_mem_mask = 16'($urandom);
        for (int k = 0; k < 20 && !done; k++) begin
            rdy = o_mem_ready;
            tick();
            done = rdy;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL push_timeout: reg %0d never accepted", r);
        end
    endtask

    task automatic wait_clear();
`ifdef VREG_CLEAR_EN
        int  n = 0;
        bit  done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            if (o_wb_enable_vector_writeback === 1'b1) n++;
            if (o_clear_busy === 1'b0) done = 1'b1;
        end
        checks++;
        if (!done || n != 32) begin
            errors++;
            $display("FAIL clear_seq: done=%b writes=%0d want done=1 writes=32", done, n);
        end
`else
        tick();
        checks++;
        if (o_clear_busy !== 1'b0 || o_mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: clear_busy=%b mem_ready=%b want 0/1", o_clear_busy, o_mem_ready);
        end
`endif
    endtask

    task automatic test_reset();
        i_reset = 1'b1; idle();
        repeat (3) tick();
        checks++;
        if (o_wb_enable_vector_writeback !== 1'b0 || o_wb_writeback_reg !== 5'd0 ||
            o_wb_writeback_value !== 512'd0 || o_wb_writeback_mask !== 16'd0) begin
            errors++;
            $display("FAIL reset_wb: en=%b reg=%0d mask=%h want all zero", o_wb_enable_vector_writeback,
                     o_wb_writeback_reg, o_wb_writeback_mask);
        end
        checks++;
        if (o_wb_stall_request !== 1'b0 || o_mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: stall=%b ready=%b want 0/0", o_wb_stall_request, o_mem_ready);
        end
        i_reset = 1'b0;
        wait_clear();
    endtask

    task automatic test_execute();
        i_ex_enable = 1'b1; i_ex_reg = 5'd5; i_ex_value = {16{32'hDEADBEEF}}; i_ex_mask = 16'h00FF;
        tick();
        i_ex_enable = 1'b0;
        checks++;
        if (o_wb_enable_vector_writeback !== 1'b1 || o_wb_writeback_reg !== 5'd5 ||
            o_wb_writeback_mask !== 16'h00FF || o_wb_writeback_value !== {16{32'hDEADBEEF}}) begin
            errors++;
            $display("FAIL exec_wb: en=%b reg=%0d mask=%h want 1/5/00ff", o_wb_enable_vector_writeback,
                     o_wb_writeback_reg, o_wb_writeback_mask);
        end
        tick();
        checks++;
        if (o_wb_enable_vector_writeback !== 1'b0) begin
            errors++;
            $display("FAIL exec_drop: en=%b want 0", o_wb_enable_vector_writeback);
        end
    endtask

    task automatic test_mem_drain();
        for (int i = 0; i < 4; i++) begin
            push_mem(5'(i + 1));
            if (i == 0) begin
                checks++;
                if (o_wb_enable_vector_writeback !== 1'b0) begin
                    errors++;
                    $display("FAIL drain_bypass: en=%b want 0 one cycle after accept", o_wb_enable_vector_writeback);
                end
            end else if (i == 1) begin
                checks++;
                if (o_wb_enable_vector_writeback !== 1'b1 || o_wb_writeback_reg !== 5'd1) begin
                    errors++;
                    $display("FAIL drain_latency: en=%b reg=%0d want 1/1", o_wb_enable_vector_writeback,
                             o_wb_writeback_reg);
                end
            end
        end
        idle();
        repeat (4) tick();
    endtask

    task automatic test_priority();
        i_mem_valid = 1'b1; i_mem_reg = 5'd7; i_mem_value = {16{32'h07070707}}; i_mem_mask = 16'hF0F0;
        i_ex_enable = 1'b1; i_ex_reg = 5'd9; i_ex_value = {16{32'h09090909}}; i_ex_mask = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            i_mem_valid = 1'b0;
            checks++;
            if (o_wb_enable_vector_writeback !== 1'b1 || o_wb_writeback_reg !== 5'd9) begin
                errors++;
                $display("FAIL prio_ex%0d: en=%b reg=%0d want 1/9", k, o_wb_enable_vector_writeback, o_wb_writeback_reg);
            end
        end
        i_ex_enable = 1'b0;
        tick();
        checks++;
        if (o_wb_enable_vector_writeback !== 1'b1 || o_wb_writeback_reg !== 5'd7) begin
            errors++;
            $display("FAIL prio_mem: en=%b reg=%0d want 1/7", o_wb_enable_vector_writeback, o_wb_writeback_reg);
        end
        repeat (2) tick();
    endtask

    task automatic test_starvation();
        i_mem_valid = 1'b1; i_mem_reg = 5'd11; i_mem_value = {16{32'h11111111}}; i_mem_mask = 16'h1234;
        i_ex_enable = 1'b1; i_ex_reg = 5'd12; i_ex_value = {16{32'h12121212}}; i_ex_mask = 16'hFFFF;
        tick();
        i_mem_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if (o_wb_stall_request !== (k >= 9)) begin
                errors++;
                $display("FAIL starve_k%0d: stall=%b want %b", k, o_wb_stall_request, (k >= 9));
            end
        end
        i_ex_enable = 1'b0;
        tick();
        checks++;
        if (o_wb_stall_request !== 1'b0 || o_wb_writeback_reg !== 5'd11) begin
            errors++;
            $display("FAIL starve_release: stall=%b reg=%0d want 0/11", o_wb_stall_request, o_wb_writeback_reg);
        end
        repeat (2) tick();
    endtask

    task automatic test_full();
        i_ex_enable = 1'b1; i_ex_reg = 5'd20; i_ex_value = {16{32'h20202020}}; i_ex_mask = 16'h00F0;
        for (int i = 0; i < 4; i++) push_mem(5'(21 + i));
        i_mem_valid = 1'b1; i_mem_reg = 5'd25; i_mem_value = {16{32'h25252525}}; i_mem_mask = 16'h0F0F;
        checks++;
        if (o_mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got %b want 0", o_mem_ready);
        end
        tick();
        i_ex_enable = 1'b0;
        checks++;
        if (o_mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_ready: got %b want 0 while popping", o_mem_ready);
        end
        tick();
        checks++;
        if (o_wb_writeback_reg !== 5'd21 || o_mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_after_pop: reg=%0d ready=%b want 21/1", o_wb_writeback_reg, o_mem_ready);
        end
        tick();
        i_mem_valid = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        i_ex_enable = 1'b1; i_ex_reg = 5'd30; i_ex_value = {16{32'h30303030}}; i_ex_mask = 16'hAAAA;
        for (int i = 0; i < 3; i++) push_mem(5'(13 + i));
        i_reset = 1'b1; idle();
        repeat (2) tick();
        checks++;
        if (o_wb_enable_vector_writeback !== 1'b0 || o_wb_writeback_reg !== 5'd0 ||
            o_wb_writeback_mask !== 16'd0 || o_wb_stall_request !== 1'b0 || o_mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_vals: en=%b reg=%0d mask=%h stall=%b ready=%b want zeros",
                     o_wb_enable_vector_writeback, o_wb_writeback_reg, o_wb_writeback_mask,
                     o_wb_stall_request, o_mem_ready);
        end
        i_reset = 1'b0;
        if (CLR) begin
            wait_clear();
        end else begin
            for (int k = 0; k < 8; k++) begin
                tick();
                if (o_wb_enable_vector_writeback === 1'b1) n++;
            end
            checks++;
            if (n != 0) begin
                errors++;
                $display("FAIL midreset_stale: %0d writebacks after release, want 0", n);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_execute();
        test_mem_drain();
        test_priority();
        test_starvation();
        test_full();
        test_reset_mid();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
